// File: rtl/hpu_pkg.sv
// Shared definitions for the HDC processing unit: hypervector geometry,
// FIFO entry layout and the word-slicing helper used by the output packer.
package hpu_pkg;

  // MSB index of a hypervector; the vector is DIM+1 bits wide.
  localparam int DIM = 1023;

  // Width of one output word on the stream port.
  localparam int OUT_W = 32;

  // Number of output words per hypervector.
  localparam int WORDS = (DIM + 1) / OUT_W;

  // Word index width. A single-word vector still needs a 1-bit index so
  // that the counter has a legal declaration.
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Index of the final word of a vector.
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS - 1);

  typedef logic [DIM:0] hv_t;

  // One buffered result: the end-of-frame tag travels with its vector.
  typedef struct packed {
    logic last;
    hv_t  vec;
  } hv_entry_t;

  // Word k of a vector, LSB word first.
  function automatic logic [OUT_W-1:0] get_word(input hv_t v,
                                                input logic [WIDX_W-1:0] k);
    return v[int'(k) * OUT_W +: OUT_W];
  endfunction

endpackage

// File: rtl/hv_fifo.sv
// DEPTH-entry synchronous FIFO of hypervector entries. The head entry and
// the entry behind it are both visible so the packer can preload its output
// registers with the next vector in the same cycle the head is popped.
// A push is accepted while full as long as a pop happens in the same cycle.
module hv_fifo
  import hpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  hv_entry_t        wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output hv_entry_t        head,
  output hv_entry_t        head_next
);

  hv_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers advance modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head      = mem[head_ptr];
  assign head_next = mem[ptr_inc(head_ptr)];

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        tail_ptr <= ptr_inc(tail_ptr);
      end
      if (do_pop) begin
        head_ptr <= ptr_inc(head_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hv_stream_packer.sv
// Captures full-width hypervector results from the HDC core, buffers them
// and serializes each one LSB word first onto a stream master port. The
// final word of a last-tagged vector carries tlast. Results arriving while
// the buffer is full and not draining are dropped and flagged by a sticky
// overflow bit.
module hv_stream_packer
  import hpu_pkg::*;
#(
  parameter int DIM   = hpu_pkg::DIM,
  parameter int OUT_W = hpu_pkg::OUT_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store,
  input  logic [DIM:0]     core_result,
  input  logic             last,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Reject geometries the slicing logic cannot represent. The entry type
  // is fixed by the shared package, so the parameters must agree with it.
  if (((DIM + 1) % OUT_W) != 0) begin : g_bad_word_width
    $error("hv_stream_packer: DIM+1 must be a multiple of OUT_W");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("hv_stream_packer: DEPTH must be at least 1");
  end
  if ((DIM != hpu_pkg::DIM) || (OUT_W != hpu_pkg::OUT_W)) begin : g_pkg_mismatch
    $error("hv_stream_packer: DIM/OUT_W must match hpu_pkg");
  end

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nx;
  logic [WIDX_W-1:0] wcnt;
  logic [WIDX_W-1:0] wcnt_nx;

  logic              fire;
  logic              pop;
  logic              store_ok;
  logic              drop;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  hv_entry_t         head;
  hv_entry_t         head_next;
  hv_entry_t         wr_entry;
  hv_entry_t         out_entry;

  assign wr_entry = {last, core_result};

  // A beat completes on a handshake; the head leaves with its final beat.
  assign fire     = m_axis_tvalid && m_axis_tready;
  assign pop      = fire && (wcnt == LAST_WIDX);

  // A slot freed by this cycle's pop can take a new vector straight away.
  assign store_ok = store && (!fifo_full || pop);
  assign drop     = store && fifo_full && !pop;

  assign busy = !fifo_empty;

  hv_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (store_ok),
    .wdata     (wr_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head),
    .head_next (head_next)
  );

  // Work out which vector and word the output registers show next cycle.
  // Looking ahead at the post-pop head is what lets consecutive vectors
  // stream without a bubble and a fresh store appear one cycle later.
  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    out_entry = head;
    if (pop) begin
      wcnt_nx = '0;
      if (fifo_count > CNT_W'(1)) begin
        out_entry = head_next;
        state_nx  = ST_STREAM;
      end else if (store_ok) begin
        out_entry = wr_entry;
        state_nx  = ST_STREAM;
      end else begin
        state_nx  = ST_EMPTY;
      end
    end else if (fire) begin
      wcnt_nx = wcnt + WIDX_W'(1);
    end else if (state == ST_EMPTY) begin
      wcnt_nx = '0;
      if (store_ok) begin
        out_entry = wr_entry;
        state_nx  = ST_STREAM;
      end
    end
  end

  // FSM, word counter and registered stream outputs; outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_EMPTY;
      wcnt          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state         <= state_nx;
      wcnt          <= wcnt_nx;
      m_axis_tvalid <= (state_nx == ST_STREAM);
      if (state_nx == ST_STREAM) begin
        m_axis_tdata <= get_word(out_entry.vec, wcnt_nx);
        m_axis_tlast <= out_entry.last && (wcnt_nx == LAST_WIDX);
      end else begin
        m_axis_tdata <= '0;
        m_axis_tlast <= 1'b0;
      end
    end
  end

  // Sticky record that at least one result was lost since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hv_stream_packer.sv
// Directed bench for hv_stream_packer with DIM=1023, OUT_W=32, DEPTH=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hv_stream_packer;
  import hpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        store;
  hv_t         core_result;
  logic        last;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        overflow;
  logic        busy;

  int tests_run;
  int tests_failed;

  hv_stream_packer #(
    .DIM   (1023),
    .OUT_W (32),
    .DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .store         (store),
    .core_result   (core_result),
    .last          (last),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .busy          (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Vector whose word k holds base+k.
  function automatic hv_t make_vec(input int base);
    hv_t v;
    v = '0;
    for (int k = 0; k < 32; k++) begin
      v[k*32 +: 32] = 32'(base + k);
    end
    return v;
  endfunction

  // Drive the upstream inputs for exactly one clock cycle.
  task automatic applyStimulus(input logic st, input hv_t vec, input logic lst);
    store       = st;
    core_result = vec;
    last        = lst;
    @(negedge clk);
  endtask

  task automatic idleInputs();
    store = 1'b0;
    last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    store         = 1'b0;
    last          = 1'b0;
    core_result   = '0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("rst_tdata", m_axis_tdata, 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Single vector, last=0, no backpressure
    applyStimulus(1'b1, make_vec(0), 1'b0);
    idleInputs();
    for (int c = 0; c < 32; c++) begin
      checkOutput("t1_tvalid", 32'(m_axis_tvalid), 32'd1);
      checkOutput("t1_tdata", m_axis_tdata, 32'(c));
      checkOutput("t1_tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    checkOutput("t1_done_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("t1_done_busy", 32'(busy), 32'd0);

    // Same vector tagged last
    applyStimulus(1'b1, make_vec(0), 1'b1);
    idleInputs();
    for (int c = 0; c < 32; c++) begin
      checkOutput("t2_tdata", m_axis_tdata, 32'(c));
      checkOutput("t2_tlast", 32'(m_axis_tlast), (c == 31) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    checkOutput("t2_done_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Backpressure: ready low on even cycles, high on odd ones
    applyStimulus(1'b1, make_vec(32'h100), 1'b0);
    idleInputs();
    for (int c = 0; c < 64; c++) begin
      m_axis_tready = (c % 2 == 1);
      checkOutput("t3_tvalid", 32'(m_axis_tvalid), 32'd1);
      checkOutput("t3_tdata", m_axis_tdata, 32'(32'h100 + c / 2));
      checkOutput("t3_tlast", 32'(m_axis_tlast), 32'd0);
      @(negedge clk);
    end
    checkOutput("t3_done_tvalid", 32'(m_axis_tvalid), 32'd0);
    m_axis_tready = 1'b1;

    // Overflow: A and B buffered, C dropped while stalled
    m_axis_tready = 1'b0;
    applyStimulus(1'b1, make_vec(32'h200), 1'b0);
    applyStimulus(1'b1, make_vec(32'h300), 1'b1);
    checkOutput("t4_ovf_before_c", 32'(overflow), 32'd0);
    applyStimulus(1'b1, make_vec(32'h400), 1'b0);
    idleInputs();
    checkOutput("t4_ovf_after_c", 32'(overflow), 32'd1);
    @(negedge clk);
    checkOutput("t4_stall_tdata", m_axis_tdata, 32'h200);
    checkOutput("t4_stall_tvalid", 32'(m_axis_tvalid), 32'd1);
    m_axis_tready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      checkOutput("t4_tvalid", 32'(m_axis_tvalid), 32'd1);
      checkOutput("t4_tdata", m_axis_tdata,
                  (c < 32) ? 32'(32'h200 + c) : 32'(32'h300 + c - 32));
      checkOutput("t4_tlast", 32'(m_axis_tlast), (c == 63) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    checkOutput("t4_done_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("t4_done_busy", 32'(busy), 32'd0);
    checkOutput("t4_ovf_sticky", 32'(overflow), 32'd1);

    // Reset after beat 10 aborts the vector and clears overflow
    applyStimulus(1'b1, make_vec(32'h800), 1'b0);
    idleInputs();
    for (int c = 0; c <= 10; c++) begin
      checkOutput("t6_tdata", m_axis_tdata, 32'(32'h800 + c));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_overflow", 32'(overflow), 32'd0);
    checkOutput("t6_rst_tdata", m_axis_tdata, 32'd0);
    @(negedge clk);
    checkOutput("t6_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
    applyStimulus(1'b1, make_vec(32'h900), 1'b0);
    idleInputs();
    for (int c = 0; c < 32; c++) begin
      checkOutput("t6_new_tvalid", 32'(m_axis_tvalid), 32'd1);
      checkOutput("t6_new_tdata", m_axis_tdata, 32'(32'h900 + c));
      @(negedge clk);
    end
    checkOutput("t6_new_done_tvalid", 32'(m_axis_tvalid), 32'd0);

    // Full FIFO: store D3 in the cycle D1's final word is accepted
    m_axis_tready = 1'b0;
    applyStimulus(1'b1, make_vec(32'h500), 1'b0);
    applyStimulus(1'b1, make_vec(32'h600), 1'b0);
    idleInputs();
    m_axis_tready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      checkOutput("t5_d1_tdata", m_axis_tdata, 32'(32'h500 + c));
      if (c == 31) begin
        store       = 1'b1;
        core_result = make_vec(32'h700);
        last        = 1'b1;
      end
      @(negedge clk);
    end
    idleInputs();
    checkOutput("t5_ovf_clear", 32'(overflow), 32'd0);
    for (int c = 0; c < 64; c++) begin
      checkOutput("t5_tvalid", 32'(m_axis_tvalid), 32'd1);
      checkOutput("t5_tdata", m_axis_tdata,
                  (c < 32) ? 32'(32'h600 + c) : 32'(32'h700 + c - 32));
      checkOutput("t5_tlast", 32'(m_axis_tlast), (c == 63) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    checkOutput("t5_done_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("t5_done_busy", 32'(busy), 32'd0);
    checkOutput("t5_ovf_final", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hv_stream_packer.md
Name: hv_stream_packer

Overview:
- Downstream stage of the HDC core. Captures each full-width hypervector result the core emits on `store`/`core_result`/`last`.
- Buffers up to DEPTH results and serializes each one into OUT_W-bit words on an AXI4-Stream-style master port toward the DMA/host.
- Marks the final word of a `last`-tagged vector with `m_axis_tlast`.
- Reports dropped results through a sticky `overflow` flag.

Parameters:
- DIM, 1023: MSB index of a hypervector; vector width is DIM+1.
- OUT_W, 32: output word width. (DIM+1) % OUT_W must equal 0; elaboration error otherwise.
- DEPTH, 2: number of hypervector slots in the capture FIFO; must be at least 1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- store  in  1  core result valid; one vector captured per cycle it is high.
- core_result  in  DIM+1  hypervector from core; sampled only when store=1.
- last  in  1  tags the vector captured this cycle as end-of-frame.
- m_axis_tdata  out  OUT_W  output word.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on the final word of a last-tagged vector.
- overflow  out  1  sticky; set when a store arrives with the FIFO full.
- busy  out  1  high while the FIFO holds any vector.

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, word counter=0, state=EMPTY, tvalid=0, tlast=0, tdata=0, overflow=0, busy=0. Reset mid-stream aborts the vector in flight; no further beats of it are emitted.
- Capture: on a cycle with store=1 and (count<DEPTH, or a slot is freed this cycle), write {last, core_result} into the tail slot.
  - Upstream guarantees single-cycle store pulses per result. Each high cycle counts as a new vector.
- Word order: word k = vector[k*OUT_W +: OUT_W], k=0..WORDS-1, with WORDS=(DIM+1)/OUT_W. LSB word first.
- Latency: store at cycle N into an empty FIFO gives tvalid=1 with word 0 at cycle N+1.
- State machine:
  - EMPTY: tvalid=0. Goes to STREAM when count becomes nonzero.
  - STREAM: tvalid=1, tdata = head word[wcnt], tlast = head.last & (wcnt==WORDS-1).
  - On tvalid&tready: wcnt increments. At wcnt==WORDS-1 the head is popped and wcnt resets to 0.
  - After a pop: stays in STREAM if count>0 after the pop, otherwise returns to EMPTY.
- Output registers: tdata, tvalid and tlast are registered.
- Handshake:
  - tdata and tlast stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake, except on rst.
  - Back-to-back vectors stream with no bubble: the cycle after the final beat of vector i shows word 0 of vector i+1.
- Full FIFO:
  - Store with count==DEPTH and no pop this cycle: the vector is dropped and overflow=1 from the next cycle until rst.
  - Store in the same cycle the final word of the head is accepted: the store is accepted and overflow is not set.
- Pointers: head and tail wrap modulo DEPTH.
- Counter: count is clog2(DEPTH+1) bits. Store and pop in the same cycle leave count unchanged.
- busy = (count != 0).

Decomposition:
- Shared package hpu_pkg holds:
  - constants DIM and OUT_W;
  - derived WORDS = (DIM+1)/OUT_W;
  - WIDX_W = clog2(WORDS);
  - typedef hv_t = logic [DIM:0];
  - typedef hv_entry_t = struct {logic last; hv_t vec;}.
- One sub-module, hv_fifo: a DEPTH-entry synchronous FIFO of hv_entry_t.
  - Ports: push, pop, full, empty, head.
  - Same-cycle push and pop are allowed when full.
- Packer top holds the word counter, the FSM, the output registers and the overflow logic.

Test Plan:
- Single vector, DIM=1023, OUT_W=32, word k = k, last=0, tready=1 -> 32 beats with tdata 0..31 on cycles N+1..N+32; tlast=0 throughout; busy drops at N+33.
- Same vector with last=1 -> tlast=1 only on beat 31 (tdata=31).
- Backpressure: tready alternating 1,0,1,0,... -> each word held stable while tready=0; 32 distinct beats, none duplicated or skipped; completes in 64 cycles.
- Overflow: tready=0, store pulses A, B, C on consecutive cycles -> A and B buffered, C dropped, overflow=1 from the cycle after C; after tready=1, 64 beats of A then B, with no gap between them.
- Simultaneous store and free: FIFO full, store D in the same cycle the final word of the head is accepted -> D accepted, overflow stays 0, D streams after the remaining vector.
- Reset mid-stream: rst after beat 10 -> next cycle tvalid=0, busy=0, overflow=0; a new store afterwards streams from word 0.
